// File: rtl/i_cache_refill.sv
// Instruction-cache line-fill engine: reads one line from backing memory and writes it into the cache array.
// The line's tag is invalidated first and revalidated at the end. Optional macro: CRITICAL_WORD_FIRST_EN.
module i_cache_refill #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADD_WIDTH       = 12,
  parameter int CACHE_ADD_WIDTH = 8,
  parameter int WORDS_PER_LINE  = 4,
  localparam int OFF_W          = $clog2(WORDS_PER_LINE),
  localparam int IDX_W          = CACHE_ADD_WIDTH - OFF_W,
  localparam int TAG_W          = ADD_WIDTH - CACHE_ADD_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADD_WIDTH-1:0]       req_addr,
  output logic [ADD_WIDTH-1:0]       mem_rdaddress,
  output logic                       mem_rden,
  input  logic [DATA_WIDTH-1:0]      mem_data_out,
  output logic [CACHE_ADD_WIDTH-1:0] cache_wraddress,
  output logic                       cache_wden,
  output logic [DATA_WIDTH-1:0]      cache_data,
  output logic                       tag_we,
  output logic [IDX_W-1:0]           tag_index,
  output logic [TAG_W-1:0]           tag_value,
  output logic                       tag_valid,
  output logic                       fill_done,
`ifdef CRITICAL_WORD_FIRST_EN
  output logic                       crit_valid,
  output logic [DATA_WIDTH-1:0]      crit_data,
`endif
  output logic [1:0]                 dbg_state
);

  // Request handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the requester must hold req_valid until then.
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [ADD_WIDTH-OFF_W-1:0] line_q, line_d;
  logic [OFF_W-1:0]          k_q, k_d;
  logic                      wr_en_q, wr_en_d;
  logic [OFF_W-1:0]          wr_off_q, wr_off_d;
  logic [OFF_W-1:0]          rd_off;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0]          crit_off_q, crit_off_d;
  logic                      first_wr_q, first_wr_d;
  // Line walk starts at the missing word and wraps around the line end.
  assign rd_off = crit_off_q + k_q;
`else
  assign rd_off = k_q;
`endif

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      k_q      <= '0;
      wr_en_q  <= 1'b0;
      wr_off_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_off_q <= '0;
      first_wr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      k_q      <= k_d;
      wr_en_q  <= wr_en_d;
      wr_off_q <= wr_off_d;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_off_q <= crit_off_d;
      first_wr_q <= first_wr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    k_d      = k_q;
    // Data returns one cycle after the read, so the write trails the read by one cycle.
    wr_en_d  = (state_q == S_READ);
    wr_off_d = rd_off;
`ifdef CRITICAL_WORD_FIRST_EN
    crit_off_d = crit_off_q;
    first_wr_d = (state_q == S_READ) && (k_q == '0);
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_READ;
          k_d     = '0;
          line_d  = req_addr[ADD_WIDTH-1:OFF_W];
`ifdef CRITICAL_WORD_FIRST_EN
          crit_off_d = req_addr[OFF_W-1:0];
`endif
        end
      end
      S_READ: begin
        k_d = k_q + 1'b1;
        if (k_q == OFF_W'(WORDS_PER_LINE - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready       = (state_q == S_IDLE);
    mem_rden        = (state_q == S_READ);
    mem_rdaddress   = mem_rden ? {line_q, rd_off} : '0;
    cache_wden      = wr_en_q;
    cache_wraddress = wr_en_q ? {line_q[IDX_W-1:0], wr_off_q} : '0;
    cache_data      = wr_en_q ? mem_data_out : '0;
    tag_we          = ((state_q == S_READ) && (k_q == '0)) || (state_q == S_DONE);
    tag_valid       = (state_q == S_DONE);
    fill_done       = (state_q == S_DONE);
    tag_index       = line_q[IDX_W-1:0];
    tag_value       = line_q[ADD_WIDTH-OFF_W-1:IDX_W];
    dbg_state       = state_q;
`ifdef CRITICAL_WORD_FIRST_EN
    crit_valid      = first_wr_q;
    crit_data       = first_wr_q ? mem_data_out : '0;
`endif
  end

endmodule

// File: tb/tb_i_cache_refill.sv
// Bench for i_cache_refill: behavioural backing memory, per-cycle expectations from the line-fill rules,
// directed scenarios followed by random fills. Honours CRITICAL_WORD_FIRST_EN when defined.
module tb_i_cache_refill;
  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [11:0] mem_rdaddress;
  logic        mem_rden;
  logic [31:0] mem_data_out = '0;
  logic [7:0]  cache_wraddress;
  logic        cache_wden;
  logic [31:0] cache_data;
  logic        tag_we;
  logic [5:0]  tag_index;
  logic [3:0]  tag_value;
  logic        tag_valid;
  logic        fill_done;
  logic [1:0]  dbg_state;
`ifdef CRITICAL_WORD_FIRST_EN
  logic        crit_valid;
  logic [31:0] crit_data;
`endif

  logic [31:0] mem [0:4095];
  logic [11:0] exp_rd_q[$];
  logic [39:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clock = ~clock;

  i_cache_refill dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .mem_rdaddress(mem_rdaddress), .mem_rden(mem_rden),
    .mem_data_out(mem_data_out), .cache_wraddress(cache_wraddress), .cache_wden(cache_wden),
    .cache_data(cache_data), .tag_we(tag_we), .tag_index(tag_index), .tag_value(tag_value),
    .tag_valid(tag_valid), .fill_done(fill_done),
`ifdef CRITICAL_WORD_FIRST_EN
    .crit_valid(crit_valid), .crit_data(crit_data),
`endif
    .dbg_state(dbg_state)
  );

  // backing memory: registered read, one cycle latency
  always @(posedge clock) if (mem_rden) mem_data_out <= mem[mem_rdaddress];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] off_of(input logic [11:0] a, input int k);
`ifdef CRITICAL_WORD_FIRST_EN
    return 2'((int'(a[1:0]) + k) % N);
`else
    return 2'(k);
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rden"}, mem_rden, 0);
    check({tag, "_rdaddr"}, mem_rdaddress, 0);
    check({tag, "_wden"}, cache_wden, 0);
    check({tag, "_wraddr"}, cache_wraddress, 0);
    check({tag, "_wdata"}, cache_data, 0);
    check({tag, "_tag_we"}, tag_we, 0);
    check({tag, "_tag_valid"}, tag_valid, 0);
    check({tag, "_fill_done"}, fill_done, 0);
    check({tag, "_ready"}, req_ready, 1);
`ifdef CRITICAL_WORD_FIRST_EN
    check({tag, "_crit_valid"}, crit_valid, 0);
    check({tag, "_crit_data"}, crit_data, 0);
`endif
  endtask

  // Driver + per-cycle checker. Entered just after a rising edge; returns in cycle N+3.
  // next_at > 0 raises req_valid with next_a from that cycle onward (request while busy).
  task automatic do_fill(input logic [11:0] a, input int next_at, input logic [11:0] next_a);
    logic [11:0] base;
    logic [39:0] w;
    base = {a[11:2], 2'b00};
    exp_rd_q.delete();
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      exp_rd_q.push_back(base + 12'(off_of(a, k)));
      exp_q.push_back({a[7:2], off_of(a, k), mem[base + 12'(off_of(a, k))]});
    end
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clock);
    check("accept_ready", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    for (int c = 1; c <= N + 2; c++) begin
      if (next_at > 0 && c == next_at) begin
        req_valid = 1'b1;
        req_addr  = next_a;
      end
      @(negedge clock);
      check("busy_ready", req_ready, 0);
      check("rden", mem_rden, (c >= 1 && c <= N));
      if (c >= 1 && c <= N) check("rdaddr", mem_rdaddress, exp_rd_q.pop_front());
      else check("rdaddr_idle", mem_rdaddress, 0);
      check("wden", cache_wden, (c >= 2 && c <= N + 1));
      if (c >= 2 && c <= N + 1) begin
        w = exp_q.pop_front();
        check("wraddr", cache_wraddress, w[39:32]);
        check("wdata", cache_data, w[31:0]);
      end
      check("tag_we", tag_we, (c == 1 || c == N + 2));
      check("tag_valid", tag_valid, (c == N + 2));
      check("fill_done", fill_done, (c == N + 2));
      check("tag_index", tag_index, a[7:2]);
      check("tag_value", tag_value, a[11:8]);
`ifdef CRITICAL_WORD_FIRST_EN
      check("crit_valid", crit_valid, (c == 2));
      check("crit_data", crit_data, (c == 2) ? mem[base + 12'(off_of(a, 0))] : 32'h0);
`endif
      @(posedge clock); #1;
    end
  endtask

  // Fill interrupted by reset in cycle 3
  task automatic do_abort(input logic [11:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clock);
    check("abort_accept", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("inval_tag_we", tag_we, 1);
    check("inval_tag_valid", tag_valid, 0);
    check("inval_index", tag_index, a[7:2]);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    check_idle_outputs("abort_rst");
    check("abort_rst_index", tag_index, 0);
    check("abort_rst_tag", tag_value, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check_idle_outputs("post_abort");
    end
    @(posedge clock); #1;
  endtask

  initial begin
    logic [11:0] cur, nxt;
    int nat;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < N; i++) mem[12'h120 + i] = 32'hA0 + i;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle_outputs("reset");
    check("reset_index", tag_index, 0);
    check("reset_tag", tag_value, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // basic fill (includes first-cycle invalidate)
    do_fill(12'h123, 0, 12'h000);
    // busy ignore: new request raised in cycle 3, taken in cycle N+3
    do_fill(12'h123, 3, 12'h040);
    do_fill(12'h040, 0, 12'h000);
    // back-to-back with held req_valid, top-of-memory line
    do_fill(12'h123, 1, 12'hFFC);
    do_fill(12'hFFC, 0, 12'h000);
    // critical-word-first ordering case
    do_fill(12'h122, 0, 12'h000);
    // reset mid-fill, then recovery
    do_abort(12'h2A5);
    do_fill(12'h2A5, 0, 12'h000);

    // random fills, sometimes chained while busy
    cur = 12'($urandom);
    for (int i = 0; i < 30; i++) begin
      nxt = 12'($urandom);
      nat = $urandom_range(0, N + 2);
      do_fill(cur, nat, nxt);
      cur = nxt;
      if (nat == 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clock);
          check("gap_idle_ready", req_ready, 1);
          @(posedge clock); #1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
